// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, sequences single-outstanding RAM reads and
// queues returned words in a 2-entry buffer for the decoder.
// Optional macro FETCH_PERF_EN adds the fetch_count / stall_count counters.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   wait_cnt, cnt_n;
  logic [ADDR_W-1:0]  pc_n, addr_n;

  // Buffer head lives directly in the instr_* output registers; slot 1 behind it.
  logic               h_valid_n;
  logic [DATA_W-1:0]  h_data_n;
  logic [ADDR_W-1:0]  h_pc_n;
  logic               s1_valid, s1_valid_n;
  logic [DATA_W-1:0]  s1_data, s1_data_n;
  logic [ADDR_W-1:0]  s1_pc, s1_pc_n;

  logic               push;
  logic               pop;

  // State, PC, address and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      ram_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_pc       <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= cnt_n;
      fetch_pc    <= pc_n;
      ram_addr    <= addr_n;
      instr_valid <= h_valid_n;
      instr_data  <= h_data_n;
      instr_pc    <= h_pc_n;
      s1_valid    <= s1_valid_n;
      s1_data     <= s1_data_n;
      s1_pc       <= s1_pc_n;
    end
  end

  // Next-state: request sequencing, buffer pop/push, redirect override
  always_comb begin
    state_n    = state;
    cnt_n      = wait_cnt;
    pc_n       = fetch_pc;
    addr_n     = ram_addr;
    h_valid_n  = instr_valid;
    h_data_n   = instr_data;
    h_pc_n     = instr_pc;
    s1_valid_n = s1_valid;
    s1_data_n  = s1_data;
    s1_pc_n    = s1_pc;
    push       = 1'b0;
    pop        = instr_valid & instr_ready;

    if (pop) begin
      h_valid_n  = s1_valid;
      h_data_n   = s1_data;
      h_pc_n     = s1_pc;
      s1_valid_n = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (fetch_en && !s1_valid) state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
        cnt_n   = CNT_W'(RD_LAT - 1);
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          push   = 1'b1;
          pc_n   = fetch_pc + ADDR_W'(1);
          addr_n = fetch_pc + ADDR_W'(1);
        end else begin
          cnt_n = wait_cnt - CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Captured word goes to the first free slot after any pop this cycle
    if (push) begin
      if (!h_valid_n) begin
        h_valid_n = 1'b1;
        h_data_n  = ram_data;
        h_pc_n    = fetch_pc;
      end else begin
        s1_valid_n = 1'b1;
        s1_data_n  = ram_data;
        s1_pc_n    = fetch_pc;
      end
      state_n = (fetch_en && !s1_valid_n) ? ST_ISSUE : ST_IDLE;
    end

    // Redirect discards buffer and any in-flight word
    if (redirect_valid) begin
      h_valid_n  = 1'b0;
      s1_valid_n = 1'b0;
      pc_n       = redirect_pc;
      addr_n     = redirect_pc;
      cnt_n      = '0;
      state_n    = fetch_en ? ST_ISSUE : ST_IDLE;
    end
  end

`ifdef FETCH_PERF_EN
  localparam int unsigned PERF_W = 16;

  // Saturating push and decoder-stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (redirect_valid)
        fetch_count <= '0;
      else if (push && (fetch_count != '1))
        fetch_count <= fetch_count + PERF_W'(1);
      if (instr_valid && !instr_ready && (stall_count != '1))
        stall_count <= stall_count + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RD_LAT=1 and RD_LAT=3) share
// stimulus; each is checked every cycle against a queue-based model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_en = 1'b0;
  logic redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic instr_ready = 1'b0;

  logic [1:0][15:0] ram_addr_w;
  logic [1:0][15:0] ram_data_w;
  logic [1:0]       valid_w;
  logic [1:0][15:0] data_w;
  logic [1:0][15:0] ipc_w;
  logic [1:0][15:0] fpc_w;
`ifdef FETCH_PERF_EN
  logic [1:0][15:0] fc_w;
  logic [1:0][15:0] sc_w;
`endif

  logic [15:0] mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [15:0] pipe [LAT];

    // RAM with registered read of LAT cycles
    always @(posedge clk) begin
      pipe[0] <= mem[ram_addr_w[g]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_data_w[g] = pipe[LAT-1];

    instr_fetch_unit #(
      .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .RD_LAT(LAT)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .fetch_en(fetch_en),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .ram_addr(ram_addr_w[g]),
      .ram_data(ram_data_w[g]),
      .instr_valid(valid_w[g]),
      .instr_data(data_w[g]),
      .instr_pc(ipc_w[g]),
      .instr_ready(instr_ready),
      .fetch_pc(fpc_w[g])
`ifdef FETCH_PERF_EN
      , .fetch_count(fc_w[g]),
      .stall_count(sc_w[g])
`endif
    );
  end

  // Behavioural model state, one set per instance
  logic [15:0] m_pc  [2];
  logic [15:0] m_qpc [2][2];
  logic [15:0] m_qd  [2][2];
  int          m_cnt [2];
  bit          m_busy[2];
  int          m_rem [2];
  logic [15:0] m_fc  [2];
  logic [15:0] m_sc  [2];

  // Words accepted by the decoder, {pc, data}
  logic [31:0] dlog0[$];
  logic [31:0] dlog1[$];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat%0d) at %0t: got %h, expected %h", name,
               (k == 0) ? 1 : 3, $time, act, exp);
    end
  endtask

  // One clock edge of the model: the request takes lat+1 edges from issue
  task automatic model_step(input int k);
    int lat;
    bit pop, cap;
    lat = (k == 0) ? 1 : 3;
    if (!rst_n) begin
      m_pc[k] = 16'h0000; m_cnt[k] = 0; m_busy[k] = 0; m_rem[k] = 0;
      m_fc[k] = 16'h0000; m_sc[k] = 16'h0000;
      return;
    end
    pop = (m_cnt[k] > 0) && instr_ready;
    if ((m_cnt[k] > 0) && !instr_ready && (m_sc[k] != 16'hFFFF)) m_sc[k]++;
    if (redirect_valid) begin
      m_cnt[k] = 0; m_pc[k] = redirect_pc; m_busy[k] = fetch_en;
      m_rem[k] = lat + 1; m_fc[k] = 16'h0000;
      return;
    end
    cap = 0;
    if (m_busy[k]) begin
      m_rem[k]--;
      if (m_rem[k] == 0) cap = 1;
    end else if (fetch_en && (m_cnt[k] < 2)) begin
      m_busy[k] = 1; m_rem[k] = lat + 1;
    end
    if (pop) begin
      m_qpc[k][0] = m_qpc[k][1];
      m_qd[k][0]  = m_qd[k][1];
      m_cnt[k]--;
    end
    if (cap) begin
      m_qpc[k][m_cnt[k]] = m_pc[k];
      m_qd[k][m_cnt[k]]  = mem[m_pc[k]];
      m_cnt[k]++;
      m_pc[k]++;
      if (m_fc[k] != 16'hFFFF) m_fc[k]++;
      m_busy[k] = fetch_en && (m_cnt[k] < 2);
      m_rem[k]  = lat + 1;
    end
  endtask

  task automatic compare(input int k);
    check("ram_addr", k, 32'(ram_addr_w[k]), 32'(m_pc[k]));
    check("fetch_pc", k, 32'(fpc_w[k]), 32'(m_pc[k]));
    check("instr_valid", k, 32'(valid_w[k]), 32'(m_cnt[k] > 0));
    if (m_cnt[k] > 0) begin
      check("instr_pc", k, 32'(ipc_w[k]), 32'(m_qpc[k][0]));
      check("instr_data", k, 32'(data_w[k]), 32'(m_qd[k][0]));
    end
`ifdef FETCH_PERF_EN
    check("fetch_count", k, 32'(fc_w[k]), 32'(m_fc[k]));
    check("stall_count", k, 32'(sc_w[k]), 32'(m_sc[k]));
`endif
  endtask

  // Model advance on each edge, compare just after it
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) compare(k);
    end
  end

  // Record decoder handshakes mid-cycle, when inputs and outputs are settled
  initial begin
    forever begin
      @(negedge clk);
      if (valid_w[0] && instr_ready) dlog0.push_back({ipc_w[0], data_w[0]});
      if (valid_w[1] && instr_ready) dlog1.push_back({ipc_w[1], data_w[1]});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [31:0] log_at(input int k, input int i);
    if (k == 0) return (i < dlog0.size()) ? dlog0[i] : 32'hDEAD_BEEF;
    return (i < dlog1.size()) ? dlog1[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int log_size(input int k);
    return (k == 0) ? dlog0.size() : dlog1.size();
  endfunction

  task automatic clear_logs();
    dlog0.delete();
    dlog1.delete();
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_valid"}, k, 32'(valid_w[k]), 32'h0);
      check({tag, "_ram_addr"}, k, 32'(ram_addr_w[k]), 32'h0000);
      check({tag, "_fetch_pc"}, k, 32'(fpc_w[k]), 32'h0000);
      check({tag, "_instr_pc"}, k, 32'(ipc_w[k]), 32'h0000);
      check({tag, "_instr_data"}, k, 32'(data_w[k]), 32'h0000);
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 12345);
    mem[16'h85A1] = 16'd1000;
    mem[16'h8449] = 16'd5000;

    // Reset state
    tick(2);
    check_reset_values("reset");

    // Sequential fetch from RESET_PC, RD_LAT=1 address spacing of two cycles
    rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    tick(2);
    check("seq_addr_t2", 0, 32'(ram_addr_w[0]), 32'h0000);
    tick(1);
    check("seq_addr_t3", 0, 32'(ram_addr_w[0]), 32'h0001);
    check("seq_first_valid", 0, 32'(valid_w[0]), 32'h1);
    check("seq_first_pc", 0, 32'(ipc_w[0]), 32'h0000);
    check("seq_first_data", 0, 32'(data_w[0]), 32'h3039);
    tick(1);
    check("seq_addr_t4", 0, 32'(ram_addr_w[0]), 32'h0001);
    tick(1);
    check("seq_addr_t5", 0, 32'(ram_addr_w[0]), 32'h0002);
    tick(12);
    for (int i = 0; i < 3; i++) begin
      check("seq_log_pc", 0, log_at(0, i) >> 16, 32'(i));
      check("seq_log_data", 0, log_at(0, i) & 32'hFFFF, 32'(mem[16'(i)]));
    end

    // Decoder stall: buffer fills with pc 0,1 and requests stop at address 2
    instr_ready = 1'b0;
    redirect_to(16'h0000);
    check("stall_flush_valid", 0, 32'(valid_w[0]), 32'h0);
    check("stall_flush_valid", 1, 32'(valid_w[1]), 32'h0);
    clear_logs();
    tick(10);
    for (int k = 0; k < 2; k++) begin
      check("stall_valid", k, 32'(valid_w[k]), 32'h1);
      check("stall_head_pc", k, 32'(ipc_w[k]), 32'h0000);
      check("stall_ram_addr", k, 32'(ram_addr_w[k]), 32'h0002);
      check("stall_no_accept", k, 32'(log_size(k)), 32'h0);
    end
    instr_ready = 1'b1;
    tick(14);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        check("stall_release_pc", k, log_at(k, i) >> 16, 32'(i));

    // Redirect to 16'h85A1
    redirect_to(16'h85A1);
    check("redir_valid_low", 0, 32'(valid_w[0]), 32'h0);
    check("redir_valid_low", 1, 32'(valid_w[1]), 32'h0);
    clear_logs();
    tick(16);
    for (int k = 0; k < 2; k++) begin
      check("redir_first", k, log_at(k, 0), 32'h85A1_03E8);
      check("redir_second_pc", k, log_at(k, 1) >> 16, 32'h85A2);
    end

    // Redirect during WAIT with one buffered entry drops both old words
    instr_ready = 1'b0;
    redirect_to(16'h3000);
    tick(3);
    check("midwait_buffered", 0, 32'(valid_w[0]), 32'h1);
    check("midwait_head_pc", 0, 32'(ipc_w[0]), 32'h3000);
    instr_ready = 1'b1;
    redirect_to(16'h8449);
    clear_logs();
    tick(16);
    for (int k = 0; k < 2; k++) begin
      check("midwait_first", k, log_at(k, 0), 32'h8449_1388);
      check("midwait_second_pc", k, log_at(k, 1) >> 16, 32'h844A);
    end

    // PC wrap
    redirect_to(16'hFFFF);
    clear_logs();
    tick(16);
    for (int k = 0; k < 2; k++) begin
      check("wrap_first_pc", k, log_at(k, 0) >> 16, 32'hFFFF);
      check("wrap_second_pc", k, log_at(k, 1) >> 16, 32'h0000);
    end

    // Async reset while the RD_LAT=3 instance is in WAIT
    redirect_to(16'h0100);
    tick(2);
    rst_n = 1'b0;
    #1;
    check_reset_values("midwait_reset");
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    tick(14);
    for (int k = 0; k < 2; k++)
      check("restart_first", k, log_at(k, 0), 32'h0000_3039);

    // Randomised traffic checked by the per-cycle model
    for (int c = 0; c < 3000; c++) begin
      fetch_en    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
      else redirect_pc = 16'($urandom);
      tick(1);
    end
    redirect_valid = 1'b0;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the RAM block.
- Owns the program counter and drives the RAM address. Waits the RAM's registered read latency, captures the returned word, and queues it in a 2-entry buffer.
- Hands words to the decoder over a valid/ready handshake, tagged with their fetch address.
- Supports control-flow redirect (jump/branch) with buffer flush.

Parameters:
- ADDR_W, 16, width of PC and RAM address
- DATA_W, 16, width of instruction word
- RESET_PC, 16'h0000, PC value after reset
- RD_LAT, 1, cycles from the edge that samples ram_addr to the edge where ram_data is valid to capture; legal 1..4

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  allow new RAM requests
- redirect_valid  in  1  load redirect_pc into PC, flush buffer
- redirect_pc  in  ADDR_W  new fetch address
- ram_addr  out  ADDR_W  address to RAM; registered
- ram_data  in  DATA_W  RAM read data
- instr_valid  out  1  head of buffer valid
- instr_data  out  DATA_W  head instruction word
- instr_pc  out  ADDR_W  address the head word was fetched from
- instr_ready  in  1  decoder accepts head this cycle
- fetch_pc  out  ADDR_W  next address to be requested

Behaviour:
- Reset (async on rst_n low, released synchronously by design):
  - state=IDLE, fetch_pc=ram_addr=RESET_PC, buffer empty.
  - instr_valid=0, instr_data=0, instr_pc=0, wait counter=0.
- States:
  - IDLE: ram_addr=fetch_pc. Go to ISSUE when fetch_en=1 and buffer count<2.
  - ISSUE: ram_addr=fetch_pc stays stable. Next edge: WAIT, counter=RD_LAT-1.
  - WAIT: counter decrements each cycle; ram_addr held. When counter==0, that edge captures ram_data, pushes {fetch_pc, ram_data} into the buffer, and does fetch_pc+=1. Then go to ISSUE if fetch_en=1 and post-push count<2, else IDLE.
- Throughput: one word per RD_LAT+1 cycles. With RD_LAT=1, address at edge N yields capture at edge N+1 and a new address at edge N+2.
- Only one request is in flight at a time. The push never overflows, because a request is issued only when count<2 and pops only reduce count.
- Buffer:
  - 2-entry FIFO.
  - instr_valid = count>0; instr_data/instr_pc = head entry.
  - Pop on instr_valid & instr_ready.
  - Simultaneous push and pop at count=1 or 2: count unchanged, order preserved.
  - instr_data/instr_pc stay stable while instr_valid=1 and instr_ready=0.
- fetch_en=0 mid-request: the in-flight request completes and is captured, then the block goes to IDLE.
- PC arithmetic: modulo 2^ADDR_W; 16'hFFFF+1 = 16'h0000, with no flag.
- Redirect (highest priority; wins over capture, push and pop in the same cycle):
  - At the edge: fetch_pc=ram_addr=redirect_pc, buffer flushed (count=0), any in-flight capture discarded.
  - Next state is ISSUE if fetch_en=1, else IDLE.
  - instr_valid=0 on the cycle after redirect.
- Reset asserted mid-WAIT: immediate return to reset values; no partial capture.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count (16 bits): increments on every buffer push, saturates at 16'hFFFF, and clears on reset and on redirect.
  - Adds output stall_count (16 bits): increments each cycle instr_valid=1 and instr_ready=0; saturates and clears on reset only.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, then fetch_en=1, instr_ready=1, RD_LAT=1 → ram_addr 0,1,2 at 2-cycle spacing; instr_pc 0,1,2 in order; instr_data matches the RAM model.
- redirect_pc=16'h85A1 with RAM model word 16'd1000 (16'h03E8) at that address → first post-redirect instr_valid has instr_pc=16'h85A1, instr_data=16'h03E8; second word tagged 16'h85A2.
- instr_ready=0 for 10 cycles from PC 0 → exactly 2 entries (pc 0, 1) buffered, ram_addr holds at 2, state IDLE; release → pc 0, 1, 2 delivered in order with no duplicates.
- Redirect to 16'h8449 asserted during WAIT with 1 buffered entry → buffer flushed, in-flight word dropped, next delivered word is 16'd5000 (16'h1388) with instr_pc=16'h8449.
- redirect_pc=16'hFFFF → words tagged 16'hFFFF then 16'h0000 (wrap).
- rst_n low mid-WAIT with RD_LAT=3 → all outputs return to reset values immediately; after release, fetch restarts from RESET_PC.
